// File: rtl/dp_sequencer_if.sv
// Instruction-fetch port between dp_sequencer (master) and instruction memory (slave).
// The fetch address stays stable while imem_req is high. imem_data is valid in the cycle imem_ack is high.
interface dp_sequencer_if #(
  parameter int PC_W = 16
) ();
  logic            imem_req;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [PC_W-1:0] pc;

  modport master (output imem_req, output pc, input imem_ack, input imem_data);
  modport slave  (input imem_req, input pc, output imem_ack, output imem_data);
endinterface

// File: rtl/dp_sequencer.sv
// Fetch/decode/execute controller for the 16-register, 16-bit ALU datapath.
// It fetches an instruction word, drives the datapath selects from it, latches the ALU flags and resolves branches.
module dp_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          start,
  dp_sequencer_if.master imem,
  input  logic [4:0]    flags,
  output logic [3:0]    readRegA,
  output logic [3:0]    readRegB,
  output logic [7:0]    Imm,
  output logic [7:0]    op,
  output logic          selectImm,
  output logic [4:0]    loadReg,
  output logic          dp_clr,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [4:0] NO_WRITE = 5'b10000;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [4:0]      psr_q, psr_d;

  logic [3:0] cls, rd, ext, rs;
  logic       is_alu, is_cmp, is_branch, cond_true;
  logic [PC_W-1:0] disp_ext;

  assign cls = ir_q[15:12];
  assign rd  = ir_q[11:8];
  assign ext = ir_q[7:4];
  assign rs  = ir_q[3:0];

  assign is_alu    = (cls <= 4'hB);
  assign is_cmp    = ((cls == 4'h0) && (ext == 4'hB)) || (cls == 4'hB);
  assign is_branch = (cls == 4'hC);
  assign disp_ext  = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

  // psr layout matches the datapath flags: {C,L,F,Z,N}
  always_comb begin
    case (rd)
      4'd0:    cond_true =  psr_q[1];
      4'd1:    cond_true = !psr_q[1];
      4'd2:    cond_true =  psr_q[4];
      4'd3:    cond_true = !psr_q[4];
      4'd4:    cond_true =  psr_q[3];
      4'd5:    cond_true = !psr_q[3];
      4'd6:    cond_true =  psr_q[2];
      4'd7:    cond_true = !psr_q[2];
      4'd8:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // NOTE: every variable gets a default first so that no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          psr_d   = '0;
        end
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_alu) psr_d = flags;
        if (is_branch && cond_true) pc_d = pc_q + disp_ext;
        else                        pc_d = pc_q + 1'b1;
        state_d = (cls == 4'hF) ? S_HALT : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that all registers update together on the edge.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end

  // The selects are decoded from ir_q, which changes only on a fetch, so they hold through DECODE and EXECUTE.
  always_comb begin
    readRegA  = '0;
    readRegB  = '0;
    Imm       = '0;
    op        = '0;
    selectImm = 1'b0;
    loadReg   = NO_WRITE;
    if (is_alu) begin
      readRegA = rd;
      readRegB = rs;
      Imm      = ir_q[7:0];
      if (cls == 4'h0) begin
        op        = {4'h0, ext};
        selectImm = 1'b0;
      end else begin
        op        = {cls, 4'h0};
        selectImm = 1'b1;
      end
      if ((state_q == S_EXEC) && !is_cmp) loadReg = {1'b0, rd};
    end
  end

  assign imem.imem_req = (state_q == S_FETCH);
  assign imem.pc       = pc_q;
  assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted        = (state_q == S_HALT);
  assign dp_clr        = (state_q == S_IDLE);

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: instruction memory responder plus a queue of hand-derived expectations.
module tb_dp_sequencer;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  imm;
    logic        sel;
    logic [4:0]  ld;
    logic [15:0] next_pc;
    logic        halt;
  } exp_t;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  flags = '0;
  logic [3:0]  readRegA, readRegB;
  logic [7:0]  Imm, op;
  logic        selectImm, dp_clr, busy, halted;
  logic [4:0]  loadReg;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  dp_sequencer_if #(.PC_W(16)) imem_bus ();

  dp_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (start),
    .imem      (imem_bus),
    .flags     (flags),
    .readRegA  (readRegA),
    .readRegB  (readRegB),
    .Imm       (Imm),
    .op        (op),
    .selectImm (selectImm),
    .loadReg   (loadReg),
    .dp_clr    (dp_clr),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_instr(input logic [15:0] instr, input int wait_cyc, input logic [4:0] flg,
                           input logic [15:0] epc, input logic [7:0] eop, input logic [3:0] ea,
                           input logic [3:0] eb, input logic [7:0] eimm, input logic esel,
                           input logic [4:0] eld, input logic [15:0] enext, input logic ehalt);
    exp_t e;
    int n;
    sb_q.push_back('{pc: epc, op: eop, a: ea, b: eb, imm: eimm, sel: esel, ld: eld,
                     next_pc: enext, halt: ehalt});
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("fetch_req", {15'd0, imem_bus.imem_req}, 16'd1);
    check("fetch_pc", imem_bus.pc, epc);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge CLK);
      check("wait_req_held", {15'd0, imem_bus.imem_req}, 16'd1);
      check("wait_pc_stable", imem_bus.pc, epc);
    end
    imem_bus.imem_ack  = 1'b1;
    imem_bus.imem_data = instr;
    flags = flg;
    @(negedge CLK);
    imem_bus.imem_ack  = 1'b0;
    imem_bus.imem_data = 16'hDEAD;
    check("decode_nowrite", {11'd0, loadReg}, 16'h0010);
    check("decode_busy", {15'd0, busy}, 16'd1);
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      check("exec_op", {8'd0, op}, {8'd0, e.op});
      check("exec_rega", {12'd0, readRegA}, {12'd0, e.a});
      check("exec_regb", {12'd0, readRegB}, {12'd0, e.b});
      check("exec_imm", {8'd0, Imm}, {8'd0, e.imm});
      check("exec_sel", {15'd0, selectImm}, {15'd0, e.sel});
      check("exec_loadreg", {11'd0, loadReg}, {11'd0, e.ld});
      @(negedge CLK);
      check("next_pc", imem_bus.pc, e.next_pc);
      check("next_halted", {15'd0, halted}, {15'd0, e.halt});
      check("next_req", {15'd0, imem_bus.imem_req}, {15'd0, !e.halt});
      check("next_nowrite", {11'd0, loadReg}, 16'h0010);
    end
  endtask

  initial begin
    imem_bus.imem_ack  = 1'b0;
    imem_bus.imem_data = 16'h0000;
    repeat (2) @(negedge CLK);
    check("rst_loadreg", {11'd0, loadReg}, 16'h0010);
    check("rst_dp_clr", {15'd0, dp_clr}, 16'd1);
    check("rst_req", {15'd0, imem_bus.imem_req}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_pc", imem_bus.pc, 16'h0000);
    check("rst_op", {8'd0, op}, 16'h0000);
    CLR = 1'b1;
    @(negedge CLK);
    check("idle_dp_clr", {15'd0, dp_clr}, 16'd1);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;

    // register-form add, then immediate form with a delayed ack
    run_instr(16'h0312, 0, 5'b00000, 16'h0000, 8'h01, 4'h3, 4'h2, 8'h12, 1'b0, 5'h03, 16'h0001, 1'b0);
    run_instr(16'h5407, 3, 5'b00000, 16'h0001, 8'h50, 4'h4, 4'h7, 8'h07, 1'b1, 5'h04, 16'h0002, 1'b0);
    // compare sets Z, NOP, BEQ taken +3
    run_instr(16'h00B1, 0, 5'b00010, 16'h0002, 8'h0B, 4'h0, 4'h1, 8'hB1, 1'b0, 5'h10, 16'h0003, 1'b0);
    run_instr(16'hD000, 0, 5'b00000, 16'h0003, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'h0004, 1'b0);
    run_instr(16'hC003, 0, 5'b00000, 16'h0004, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'h0007, 1'b0);
    // compare clears Z, BEQ not taken
    run_instr(16'h00B1, 1, 5'b00000, 16'h0007, 8'h0B, 4'h0, 4'h1, 8'hB1, 1'b0, 5'h10, 16'h0008, 1'b0);
    run_instr(16'hC003, 0, 5'b11111, 16'h0008, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'h0009, 1'b0);
    // unconditional branch backwards to 0xFFFF, then PC wraps to 0
    run_instr(16'hC8F6, 0, 5'b00000, 16'h0009, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'hFFFF, 1'b0);
    run_instr(16'h0312, 0, 5'b00000, 16'hFFFF, 8'h01, 4'h3, 4'h2, 8'h12, 1'b0, 5'h03, 16'h0000, 1'b0);
    // never-condition, immediate compare sets C, BCS disp=-2
    run_instr(16'hC905, 0, 5'b00000, 16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'h0001, 1'b0);
    run_instr(16'hB3FF, 0, 5'b10000, 16'h0001, 8'hB0, 4'h3, 4'hF, 8'hFF, 1'b1, 5'h10, 16'h0002, 1'b0);
    run_instr(16'hC2FE, 0, 5'b00000, 16'h0002, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'h0000, 1'b0);
    // halt
    run_instr(16'hF000, 0, 5'b00000, 16'h0000, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 5'h10, 16'h0001, 1'b1);
    check("halt_busy", {15'd0, busy}, 16'd0);
    check("halt_dp_clr", {15'd0, dp_clr}, 16'd0);
    @(negedge CLK);
    check("halt_stays", {15'd0, halted}, 16'd1);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("restart_pc", imem_bus.pc, 16'h0000);
    check("restart_req", {15'd0, imem_bus.imem_req}, 16'd1);
    check("restart_halted", {15'd0, halted}, 16'd0);

    // asynchronous reset in the middle of a writing EXECUTE
    imem_bus.imem_ack  = 1'b1;
    imem_bus.imem_data = 16'h0312;
    @(negedge CLK);
    imem_bus.imem_ack = 1'b0;
    @(negedge CLK);
    check("pre_rst_loadreg", {11'd0, loadReg}, 16'h0003);
    #3 CLR = 1'b0;
    #1;
    check("midrst_loadreg", {11'd0, loadReg}, 16'h0010);
    check("midrst_dp_clr", {15'd0, dp_clr}, 16'd1);
    check("midrst_req", {15'd0, imem_bus.imem_req}, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_pc", imem_bus.pc, 16'h0000);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    check("post_rst_idle", {15'd0, dp_clr}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
